// File: rtl/data_pattern_generator.sv
`timescale 1ns/1ps
// PRBS word source with an Avalon-MM CSR slave and a valid/ready stream output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stream off, aso_valid low, waiting for ENABLE
// LOAD  | latch SEL, seed the LFSR, compute the first word (one cycle)
// RUN   | present words, advance on every accepted transfer
module data_pattern_generator #(
  parameter int          DATA_W  = 64,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic              csr_clk_clk,
  input  logic              reset_reset,
  input  logic [2:0]        csr_slave_address,
  input  logic              csr_slave_write,
  input  logic              csr_slave_read,
  input  logic [3:0]        csr_slave_byteenable,
  input  logic [31:0]       csr_slave_writedata,
  output logic [31:0]       csr_slave_readdata,
  output logic [DATA_W-1:0] aso_data,
  output logic              aso_valid,
  input  logic              aso_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state, state_next;
  logic              ctrl_enable;
  logic [1:0]        ctrl_sel;
  logic              inject_pending;
  logic [30:0]       seed;
  logic [63:0]       word_count;
  logic [31:0]       words_hi_shadow;
  logic [1:0]        run_sel;
  logic [30:0]       lfsr;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              valid_next;
  logic              advance;
  logic [31:0]       rd_mux;
  logic [30:0]       seed_masked;
  logic [30:0]       seed_init;
  logic [1:0]        gen_sel;
  logic [30:0]       gen_state;
  logic [DATA_W-1:0] gen_word;
  logic [30:0]       s;
  logic              fb;
  logic              wd_unused;

  logic wr_ctrl, wr_seed, wr_clear, xfer;
  assign wr_ctrl   = csr_slave_write && (csr_slave_address == 3'd0);
  assign wr_seed   = csr_slave_write && (csr_slave_address == 3'd2);
  assign wr_clear  = csr_slave_write && (csr_slave_address == 3'd5)
                     && csr_slave_byteenable[0] && csr_slave_writedata[0];
  assign xfer      = valid_q && aso_ready;
  assign wd_unused = csr_slave_writedata[31];

  function automatic logic [30:0] order_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    order_mask = 31'h0000_007F;
      2'd1:    order_mask = 31'h0000_7FFF;
      2'd2:    order_mask = 31'h007F_FFFF;
      default: order_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  // Seed trimmed to the selected order; an all-zero seed would lock the LFSR, so use all-ones.
  always_comb begin
    seed_masked = seed & order_mask(ctrl_sel);
    seed_init   = (seed_masked == 31'd0) ? order_mask(ctrl_sel) : seed_masked;
  end

  // DATA_W serial Fibonacci steps unrolled; first feedback bit lands in bit 0.
  always_comb begin
    gen_sel  = (state == LOAD) ? ctrl_sel : run_sel;
    s        = (state == LOAD) ? seed_init : lfsr;
    fb       = 1'b0;
    gen_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (gen_sel)
        2'd0:    fb = s[6]  ^ s[5];
        2'd1:    fb = s[14] ^ s[13];
        2'd2:    fb = s[22] ^ s[17];
        default: fb = s[30] ^ s[27];
      endcase
      s = {s[29:0], fb} & order_mask(gen_sel);
      gen_word[i] = fb;
    end
    gen_state = s;
  end

  // Next-state and stream control.
  always_comb begin
    state_next = state;
    valid_next = valid_q;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        valid_next = 1'b0;
        if (ctrl_enable) state_next = LOAD;
      end
      LOAD: begin
        advance    = 1'b1;
        valid_next = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (!ctrl_enable) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else if (xfer) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // FSM, LFSR and output word registers.
  always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      lfsr    <= '1;
      run_sel <= 2'd0;
    end else begin
      state   <= state_next;
      valid_q <= valid_next;
      if (advance) begin
        data_q <= gen_word;
        lfsr   <= gen_state;
      end
      if (state == LOAD) run_sel <= ctrl_sel;
    end
  end

  // The pending error flips bit 0 of whatever word is on offer, so the accepted one carries it.
  assign aso_data  = data_q ^ {{(DATA_W-1){1'b0}}, inject_pending & valid_q};
  assign aso_valid = valid_q;

  // CSR writes, inject flag and transfer counter.
  always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_enable    <= 1'b0;
      ctrl_sel       <= 2'd0;
      inject_pending <= 1'b0;
      seed           <= '0;
      word_count     <= '0;
    end else begin
      if (wr_ctrl && csr_slave_byteenable[0]) begin
        ctrl_enable <= csr_slave_writedata[0];
        ctrl_sel    <= csr_slave_writedata[2:1];
      end
      inject_pending <= (inject_pending && !xfer)
                        || (wr_ctrl && csr_slave_byteenable[1] && csr_slave_writedata[8]);
      if (wr_seed) begin
        if (csr_slave_byteenable[0]) seed[7:0]   <= csr_slave_writedata[7:0];
        if (csr_slave_byteenable[1]) seed[15:8]  <= csr_slave_writedata[15:8];
        if (csr_slave_byteenable[2]) seed[23:16] <= csr_slave_writedata[23:16];
        if (csr_slave_byteenable[3]) seed[30:24] <= csr_slave_writedata[30:24];
      end
      if (wr_clear)  word_count <= '0;
      else if (xfer) word_count <= word_count + 64'd1;
    end
  end

  // Read mux.
  always_comb begin
    case (csr_slave_address)
      3'd0:    rd_mux = {29'd0, ctrl_sel, ctrl_enable};
      3'd1:    rd_mux = {30'd0, inject_pending, state == RUN};
      3'd2:    rd_mux = {1'b0, seed};
      3'd3:    rd_mux = word_count[31:0];
      3'd4:    rd_mux = words_hi_shadow;
      3'd6:    rd_mux = VERSION;
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read data; reading WORDS_LO freezes the upper half for a coherent 64-bit read.
  always_ff @(posedge csr_clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      csr_slave_readdata <= 32'd0;
      words_hi_shadow    <= 32'd0;
    end else if (csr_slave_read) begin
      csr_slave_readdata <= rd_mux;
      if (csr_slave_address == 3'd3) words_hi_shadow <= word_count[63:32];
    end
  end

endmodule

// File: tb/tb_data_pattern_generator.sv
`timescale 1ns/1ps
// Directed + randomized bench for data_pattern_generator with a bit-serial PRBS model.
module tb_data_pattern_generator;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        addr = '0;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [3:0]        be = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] aso_data;
  logic              aso_valid;
  logic              aso_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] got[$];
  logic [63:0] mw[0:429];

  logic [31:0] m_s, m_mask;
  int          m_n, m_t;

  data_pattern_generator #(.DATA_W(DATA_W), .VERSION(32'h0001_0000)) dut (
    .csr_clk_clk          (clk),
    .reset_reset          (rst),
    .csr_slave_address    (addr),
    .csr_slave_write      (wr),
    .csr_slave_read       (rd),
    .csr_slave_byteenable (be),
    .csr_slave_writedata  (wdata),
    .csr_slave_readdata   (readdata),
    .aso_data             (aso_data),
    .aso_valid            (aso_valid),
    .aso_ready            (aso_ready)
  );

  always #5 clk = ~clk;

  // Record every word that will be accepted at the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (aso_valid === 1'b1 && aso_ready === 1'b1) got.push_back(aso_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init(input logic [31:0] sd, input logic [1:0] sel);
    case (sel)
      2'd0:    begin m_n = 7;  m_t = 6;  end
      2'd1:    begin m_n = 15; m_t = 14; end
      2'd2:    begin m_n = 23; m_t = 18; end
      default: begin m_n = 31; m_t = 28; end
    endcase
    m_mask = (32'd1 << m_n) - 32'd1;
    m_s    = sd & m_mask;
    if (m_s == 32'd0) m_s = m_mask;
  endtask

  task automatic model_word(output logic [63:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      b   = m_s[m_n-1] ^ m_s[m_t-1];
      m_s = ((m_s << 1) | {31'd0, b}) & m_mask;
      w[i] = b;
    end
  endtask

  task automatic csr_write_be(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    csr_write_be(a, d, 4'hF);
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = readdata;
  endtask

  // Accept exactly n words (ready optionally random), then stall.
  task automatic collect(input int n, input bit rnd);
    int budget;
    budget = n * 8 + 100;
    while (got.size() < n && budget > 0) begin
      aso_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      budget--;
    end
    aso_ready = 1'b0;
    check("collect_count", 64'(got.size()), 64'(n));
  endtask

  task automatic compare_model(input string tag, input int n);
    logic [63:0] w;
    for (int k = 0; k < n; k++) begin
      model_word(w);
      if (k < got.size()) check(tag, got[k], w);
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic [63:0] w, w_hold;
    logic [1:0]  sel, sel2;
    logic [31:0] sd;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", aso_valid, 0);
    check("rst_data", aso_data, 0);
    check("rst_readdata", readdata, 0);
    rst = 1'b0;
    csr_read(3'd0, rv); check("rst_ctrl", rv, 0);
    csr_read(3'd1, rv); check("rst_status", rv, 0);
    csr_read(3'd2, rv); check("rst_seed", rv, 0);
    csr_read(3'd3, rv); check("rst_words_lo", rv, 0);
    csr_read(3'd7, rv); check("reserved", rv, 0);
    csr_read(3'd6, rv); check("version", rv, 32'h0001_0000);
    repeat (3) @(negedge clk);
    check("readdata_hold", readdata, 32'h0001_0000);

    // PRBS7, valid latency, periodicity
    csr_write(3'd2, 32'h7F);
    got.delete();
    csr_write(3'd0, 32'h1);
    check("valid_lat0", aso_valid, 0);
    @(negedge clk); check("valid_lat1", aso_valid, 0);
    @(negedge clk); check("valid_lat2", aso_valid, 1);
    collect(430, 1'b0);
    model_init(32'h7F, 2'd0);
    for (int k = 0; k < 430; k++) model_word(mw[k]);
    for (int k = 0; k < 430; k++) check("prbs7_word", got[k], mw[k]);
    for (int k = 0; k < 300; k++) check("prbs7_period", got[k+127], mw[k]);
    csr_read(3'd3, rv); check("cnt430_lo", rv, 430);
    csr_read(3'd4, rv); check("cnt430_hi", rv, 0);

    // Stall: data held, counter held, no word skipped on release
    model_word(w_hold);
    repeat (10) begin
      @(negedge clk);
      check("hold_data", aso_data, w_hold);
    end
    csr_read(3'd3, rv); check("hold_cnt", rv, 430);
    got.delete();
    collect(20, 1'b1);
    check("resume_first", got[0], w_hold);
    for (int k = 1; k < 20; k++) begin
      model_word(w);
      check("resume_word", got[k], w);
    end

    // Error injection
    model_word(w_hold);
    csr_write(3'd0, 32'h101);
    csr_read(3'd1, rv); check("status_pending", rv, 3);
    csr_read(3'd0, rv); check("ctrl_inject_rd0", rv, 1);
    check("inject_data", aso_data, w_hold ^ 64'd1);
    got.delete();
    collect(10, 1'b0);
    check("inject_word", got[0], w_hold ^ 64'd1);
    for (int k = 1; k < 10; k++) begin
      model_word(w);
      check("post_inject_word", got[k], w);
    end
    csr_read(3'd1, rv); check("status_cleared", rv, 1);

    // Randomized seeds/orders with random backpressure; mid-run SEL/SEED writes ignored
    for (int it = 0; it < 4; it++) begin
      csr_write(3'd0, 32'h0);
      repeat (2) @(negedge clk);
      check("disable_valid", aso_valid, 0);
      csr_read(3'd1, rv); check("disable_status", rv, 0);
      sel = 2'($urandom_range(0, 3));
      sd  = $urandom;
      csr_write(3'd2, sd);
      model_init(sd, sel);
      got.delete();
      csr_write(3'd0, {29'd0, sel, 1'b1});
      collect(100, 1'b1);
      compare_model("rand_word_a", 100);
      sel2 = sel + 2'd1;
      csr_write(3'd2, $urandom);
      csr_write(3'd0, {29'd0, sel2, 1'b1});
      csr_read(3'd1, rv); check("rand_running", rv, 1);
      got.delete();
      collect(100, 1'b1);
      compare_model("rand_word_b", 100);
    end

    // PRBS31: seed 0 behaves as all-ones
    csr_write(3'd0, 32'h0);
    repeat (2) @(negedge clk);
    csr_write(3'd2, 32'h0);
    model_init(32'h7FFF_FFFF, 2'd3);
    got.delete();
    csr_write(3'd0, 32'h7);
    collect(16, 1'b0);
    compare_model("prbs31_seed0", 16);
    csr_write(3'd0, 32'h0);
    repeat (2) @(negedge clk);
    csr_write(3'd2, 32'h7FFF_FFFF);
    csr_write(3'd5, 32'h1);
    model_init(32'h7FFF_FFFF, 2'd3);
    got.delete();
    csr_write(3'd0, 32'h7);
    collect(1000, 1'b0);
    compare_model("prbs31_word", 1000);
    for (int k = 0; k < 1000; k++) check("nonzero", 64'(got[k] == 64'd0), 0);
    csr_read(3'd3, rv); check("cnt1000_lo", rv, 1000);
    csr_read(3'd4, rv); check("cnt1000_hi", rv, 0);

    // Byte enables
    csr_write_be(3'd2, 32'h0000_0012, 4'b0001);
    csr_read(3'd2, rv); check("seed_be", rv, 32'h7FFF_FF12);
    csr_write_be(3'd0, 32'h0, 4'b0010);
    csr_read(3'd0, rv); check("ctrl_be", rv, 7);

    // CLEAR coinciding with a transfer
    @(negedge clk);
    addr = 3'd5; wdata = 32'h1; be = 4'hF; wr = 1'b1; aso_ready = 1'b1;
    check("clear_xfer_valid", aso_valid, 1);
    @(negedge clk);
    wr = 1'b0; aso_ready = 1'b0;
    csr_read(3'd3, rv); check("clear_wins_lo", rv, 0);
    csr_read(3'd4, rv); check("clear_wins_hi", rv, 0);

    // Reset mid-run
    @(negedge clk); aso_ready = 1'b1;
    @(negedge clk); #1;
    check("pre_reset_valid", aso_valid, 1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", aso_valid, 0);
    check("async_reset_data", aso_data, 0);
    @(negedge clk);
    rst = 1'b0;
    csr_read(3'd0, rv); check("post_reset_ctrl", rv, 0);
    csr_read(3'd1, rv); check("post_reset_status", rv, 0);
    csr_read(3'd3, rv); check("post_reset_cnt", rv, 0);
    got.delete();
    repeat (20) @(negedge clk);
    check("no_words_after_reset", 64'(got.size()), 0);
    check("post_reset_valid", aso_valid, 0);
    model_init(32'h0, 2'd0);
    csr_write(3'd0, 32'h1);
    collect(5, 1'b0);
    compare_model("rerun_word", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
